// File: rtl/usb_fs_pkg.sv
// Shared PID constants and state encodings
// for the full-speed USB device IN path.
package usb_fs_pkg;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [1:0] {
        EP_READY     = 2'd0,
        EP_PKT_READY = 2'd1,
        EP_STALL     = 2'd2
    } ep_state_t;

    typedef enum logic [1:0] {
        XF_IDLE     = 2'd0,
        XF_SEND     = 2'd1,
        XF_WAIT_TX  = 2'd2,
        XF_WAIT_ACK = 2'd3
    } xfer_state_t;

endpackage

// File: rtl/usb_fs_in_ep_buf.sv
// One IN endpoint: packet buffer, fill pointer,
// committed length, endpoint state and data toggle.
module usb_fs_in_ep_buf
    import usb_fs_pkg::*;
#(
    parameter int MAX_SIZE = 32,
    parameter int AW       = $clog2(MAX_SIZE) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_ep,
    input  logic          put,
    input  logic [7:0]    data,
    input  logic          done,
    input  logic          stall,
    input  logic          setup,
    input  logic          ack,
    input  logic [AW-2:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          free,
    output logic [AW-1:0] length,
    output logic          toggle,
    output logic          acked,
    output ep_state_t     state
);

    localparam logic [AW-1:0] MAX_A = AW'(MAX_SIZE);

    logic [7:0]    mem [MAX_SIZE];
    logic [AW-1:0] put_addr;
    logic          free_raw;
    logic          wr;

    assign free_raw = (state == EP_READY) && (put_addr < MAX_A);
    // Held low while the block is in reset so every output reads 0.
    assign free     = reset && free_raw;
    assign wr       = put && free_raw && !reset_ep && !stall;
    assign rd_data  = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr) mem[put_addr[AW-2:0]] <= data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EP_READY;
            put_addr <= '0;
            length   <= '0;
            toggle   <= 1'b0;
            acked    <= 1'b0;
        end else begin
            acked <= 1'b0;
            if (reset_ep) begin
                state    <= EP_READY;
                put_addr <= '0;
                toggle   <= 1'b0;
            end else begin
                if (stall) begin
                    state    <= EP_STALL;
                    put_addr <= '0;
                end else begin
                    case (state)
                        EP_READY: begin
                            if (wr) put_addr <= put_addr + 1'b1;
                            if (done) begin
                                state  <= EP_PKT_READY;
                                length <= put_addr + AW'(wr);
                            end
                        end
                        EP_PKT_READY: begin
                            if (ack) begin
                                state    <= EP_READY;
                                put_addr <= '0;
                                toggle   <= ~toggle;
                                acked    <= 1'b1;
                            end
                        end
                        EP_STALL: begin
                            if (setup) state <= EP_READY;
                        end
                        default: state <= EP_READY;
                    endcase
                end
                if (setup) toggle <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_fs_in_pe.sv
// IN protocol engine: answers IN tokens with DATA0/1,
// NAK or STALL and retries until the host ACKs.
module usb_fs_in_pe
    import usb_fs_pkg::*;
#(
    parameter int NUM_IN_EPS         = 1,
    parameter int MAX_IN_PACKET_SIZE = 32,
    parameter int ACK_TIMEOUT        = 72
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IN_EPS-1:0] reset_ep,
    input  logic [6:0]            dev_addr,
    output logic [NUM_IN_EPS-1:0] in_ep_data_free,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
    input  logic [7:0]            in_ep_data,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
    input  logic [NUM_IN_EPS-1:0] in_ep_stall,
    output logic [NUM_IN_EPS-1:0] in_ep_acked,
    input  logic                  rx_pkt_start,
    input  logic                  rx_pkt_end,
    input  logic                  rx_pkt_valid,
    input  logic [3:0]            rx_pid,
    input  logic [6:0]            rx_addr,
    input  logic [3:0]            rx_endp,
    output logic                  tx_pkt_start,
    input  logic                  tx_pkt_end,
    output logic [3:0]            tx_pid,
    output logic                  tx_data_avail,
    input  logic                  tx_data_get,
    output logic [7:0]            tx_data
);

    localparam int AW = $clog2(MAX_IN_PACKET_SIZE) + 1;
    localparam int EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

    logic [7:0]    ep_rd_data [NUM_IN_EPS];
    logic [AW-1:0] ep_len     [NUM_IN_EPS];
    ep_state_t     ep_st      [NUM_IN_EPS];
    logic [NUM_IN_EPS-1:0] ep_tog;
    logic [NUM_IN_EPS-1:0] cur_oh;

    xfer_state_t   xf_state, xf_next;
    logic [EW-1:0] cur, cur_next;
    logic [AW-1:0] get_addr, get_next;
    logic [TW-1:0] timer, timer_next;
    logic          abort, abort_next;
    logic [3:0]    pid_q, pid_next, pid_sel;
    logic          rx_busy;
    logic          ack_cur;

    ep_state_t     sel_st;
    logic [AW-1:0] sel_len;
    logic [7:0]    sel_data;
    logic          sel_tog;

    logic tok_ok, in_tok, setup_tok, ack_rx, reset_cur;

    assign tok_ok    = rx_pkt_end && rx_pkt_valid &&
                       (rx_addr == dev_addr) &&
                       (int'(rx_endp) < NUM_IN_EPS);
    assign in_tok    = tok_ok && (rx_pid == PID_IN);
    assign setup_tok = tok_ok && (rx_pid == PID_SETUP);
    assign ack_rx    = rx_pkt_end && rx_pkt_valid &&
                       (rx_pid == PID_ACK);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN_EPS; gi++) begin : g_ep
            usb_fs_in_ep_buf #(
                .MAX_SIZE (MAX_IN_PACKET_SIZE)
            ) u_buf (
                .clk      (clk),
                .reset    (reset),
                .reset_ep (reset_ep[gi]),
                .put      (in_ep_data_put[gi]),
                .data     (in_ep_data),
                .done     (in_ep_data_done[gi]),
                .stall    (in_ep_stall[gi]),
                .setup    (setup_tok && (rx_endp == 4'(gi))),
                .ack      (ack_cur && cur_oh[gi]),
                .rd_addr  (get_addr[AW-2:0]),
                .rd_data  (ep_rd_data[gi]),
                .free     (in_ep_data_free[gi]),
                .length   (ep_len[gi]),
                .toggle   (ep_tog[gi]),
                .acked    (in_ep_acked[gi]),
                .state    (ep_st[gi])
            );
        end
    endgenerate

    always_comb begin
        cur_oh   = '0;
        sel_st   = EP_READY;
        sel_len  = '0;
        sel_data = '0;
        sel_tog  = 1'b0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (cur == EW'(i)) begin
                cur_oh[i] = 1'b1;
                sel_st    = ep_st[i];
                sel_len   = ep_len[i];
                sel_data  = ep_rd_data[i];
                sel_tog   = ep_tog[i];
            end
        end
    end

    assign reset_cur     = |(reset_ep & cur_oh);
    assign tx_data_avail = (xf_state == XF_WAIT_TX) && !abort &&
                           (get_addr < sel_len);
    assign tx_data       = tx_data_avail ? sel_data : 8'h00;
    assign tx_pid        = (xf_state == XF_SEND) ? pid_sel : pid_q;

    always_comb begin
        xf_next      = xf_state;
        cur_next     = cur;
        get_next     = get_addr;
        timer_next   = timer;
        abort_next   = abort;
        pid_next     = pid_q;
        pid_sel      = pid_q;
        tx_pkt_start = 1'b0;
        ack_cur      = 1'b0;
        case (xf_state)
            XF_IDLE: begin
                abort_next = 1'b0;
                if (in_tok) begin
                    cur_next = rx_endp[EW-1:0];
                    xf_next  = XF_SEND;
                end
            end
            XF_SEND: begin
                if (reset_cur) begin
                    xf_next = XF_IDLE;
                end else begin
                    tx_pkt_start = 1'b1;
                    unique case (1'b1)
                        (sel_st == EP_STALL): begin
                            pid_sel = PID_STALL;
                            xf_next = XF_IDLE;
                        end
                        (sel_st == EP_PKT_READY): begin
                            pid_sel  = sel_tog ? PID_DATA1 : PID_DATA0;
                            get_next = '0;
                            xf_next  = XF_WAIT_TX;
                        end
                        default: begin
                            pid_sel = PID_NAK;
                            xf_next = XF_IDLE;
                        end
                    endcase
                    pid_next = pid_sel;
                end
            end
            XF_WAIT_TX: begin
                if (reset_cur) abort_next = 1'b1;
                if (tx_data_get && tx_data_avail)
                    get_next = get_addr + 1'b1;
                if (tx_pkt_end) begin
                    timer_next = '0;
                    xf_next = (abort || reset_cur) ? XF_IDLE
                                                   : XF_WAIT_ACK;
                end
            end
            XF_WAIT_ACK: begin
                timer_next = timer + 1'b1;
                if (reset_cur) begin
                    xf_next = XF_IDLE;
                end else if (rx_pkt_end) begin
                    ack_cur = ack_rx;
                    xf_next = XF_IDLE;
                end else if (timer == TMAX && !rx_busy) begin
                    // a handshake already in flight is allowed to finish
                    xf_next = XF_IDLE;
                end
            end
            default: xf_next = XF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xf_state <= XF_IDLE;
            cur      <= '0;
            get_addr <= '0;
            timer    <= '0;
            abort    <= 1'b0;
            pid_q    <= 4'h0;
            rx_busy  <= 1'b0;
        end else begin
            xf_state <= xf_next;
            cur      <= cur_next;
            get_addr <= get_next;
            timer    <= timer_next;
            abort    <= abort_next;
            pid_q    <= pid_next;
            if (rx_pkt_start)    rx_busy <= 1'b1;
            else if (rx_pkt_end) rx_busy <= 1'b0;
        end
    end

endmodule

// File: doc/usb_fs_in_pe.md
# usb_fs_in_pe

IN protocol engine for the full-speed USB device core: buffers packets written by endpoint logic and returns them to the host on IN tokens. It answers with DATA0/DATA1, NAK or STALL, waits for the host handshake, and retransmits unacknowledged data. It sits beside the OUT engine, shares the rx token decode path, and drives the tx packet engine.

## Interface
- NUM_IN_EPS, 1, number of IN endpoints (1..16)
- MAX_IN_PACKET_SIZE, 32, bytes per endpoint buffer (power of two, ≤64)
- ACK_TIMEOUT, 72, clk cycles after tx_pkt_end to wait for a host handshake
- clk  in  1  core clock; sole clock domain
- reset  in  1  asynchronous, active-low (asserted at 0) block reset
- reset_ep  in  NUM_IN_EPS  sync per-endpoint clear
- dev_addr  in  7  assigned device address
- in_ep_data_free  out  NUM_IN_EPS  endpoint accepts bytes
- in_ep_data_put  in  NUM_IN_EPS  write strobe, one-hot
- in_ep_data  in  8  byte written on put
- in_ep_data_done  in  NUM_IN_EPS  commit buffered bytes as one packet
- in_ep_stall  in  NUM_IN_EPS  endpoint halted
- in_ep_acked  out  NUM_IN_EPS  1-cycle pulse when host ACKs a packet
- rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  rx packet strobes
- rx_pid  in  4; rx_addr  in  7; rx_endp  in  4  decoded fields of last packet
- tx_pkt_start  out  1  1-cycle strobe to send packet
- tx_pkt_end  in  1  tx engine finished packet
- tx_pid  out  4  PID for tx packet, held until tx_pkt_end
- tx_data_avail  out  1  payload bytes remain
- tx_data_get  in  1  tx engine consumes tx_data
- tx_data  out  8  current payload byte

## Operation
- Reset values: all outputs 0; toggles 0; all endpoints READY; FSM IDLE.
- Endpoint states: READY (filling), PKT_READY (committed), STALL.
- READY: put with free high writes buf[put_addr], put_addr++. free = READY && put_addr < MAX_IN_PACKET_SIZE; puts while free low are dropped. done → PKT_READY, length = put_addr (zero-length allowed). put+done same cycle: byte included.
- PKT_READY → READY only on host ACK (put_addr cleared, toggle flipped, in_ep_acked pulse).
- in_ep_stall high → STALL from any state, buffer discarded. STALL → READY on SETUP token to that endpoint with stall low.
- SETUP token (pid 1101) to endpoint sets its toggle to 1.
- Token accepted: rx_pkt_end && rx_pkt_valid && rx_addr==dev_addr && rx_endp<NUM_IN_EPS.
- Transfer FSM: IDLE → (IN token, pid 1001) latch current_endp, go SEND.
- SEND: strobe tx_pkt_start. STALL→pid 1110, go IDLE. READY→pid 1010 (NAK), go IDLE. PKT_READY→pid DATA0 0011 / DATA1 1011 per toggle, get_addr=0, go WAIT_TX.
- WAIT_TX: tx_data = buf[current_endp][get_addr]; tx_data_avail = get_addr<length; tx_data_get increments get_addr. tx_pkt_end → WAIT_ACK, timer cleared.
- WAIT_ACK: valid ACK (pid 0010) → commit ACK as above, IDLE. Any other packet end, invalid packet, or timer == ACK_TIMEOUT → IDLE, data and toggle kept for retry.
- reset_ep[i]: endpoint i → READY, put_addr 0, toggle 0; if current_endp==i, FSM → IDLE after any in-flight tx_pkt_end.

## Timing
- IN token at cycle T (rx_pkt_end) → tx_pkt_start at T+1.
- tx_data combinational from get_addr; valid same cycle as tx_data_avail.
- ACK at cycle A → in_ep_acked, free high at A+1.
- Timer counts from the cycle after tx_pkt_end; timeout fires on cycle ACK_TIMEOUT.
- reset is asynchronous; every other input sampled on rising clk.

## Structure
- usb_fs_pkg: PID constants (IN, SETUP, ACK, NAK, STALL, DATA0/1), endpoint and transfer state enums.
- Sub-module usb_fs_in_ep_buf: one endpoint's buffer, put_addr, length, state and toggle; generated NUM_IN_EPS times, read port muxed by current_endp.

## Test plan
- Put 0x11,0x22,0x33 + done on EP0; IN to EP0 → tx_pid 0011, bytes 11,22,33, avail low after 3 gets; host ACK → in_ep_acked[0] pulse, next packet DATA1.
- IN to empty EP0 → NAK (1010), no data, state unchanged.
- Packet sent, no ACK for ACK_TIMEOUT cycles → IDLE; repeat IN → same bytes, same DATA0.
- in_ep_stall[0] with PKT_READY; IN → STALL (1110); SETUP to EP0 with stall low → READY, toggle 1.
- 40 puts on 32-byte buffer → free drops after 32, packet length 32; done with zero puts → zero-length DATA packet.
- reset low during WAIT_TX → all outputs 0 immediately; after release IN → NAK.
